// File: rtl/gf_pow_seq.sv
// Sequential GF(2^N) exponentiator: base^exp mod poly by left-to-right square-and-multiply,
// one exponent bit per clock, built on two chained combinational field multipliers.

module galois_multiplication #(
    parameter int N = 8
) (
    input  logic [2*N-2:0] a,
    input  logic [2*N-2:0] b,
    input  logic [N:0]     p,
    output logic [N-1:0]   y
);
    localparam int PW = 4*N-3;

    logic [PW-1:0] pp [2*N-1];
    logic [PW-1:0] prod;

    generate
        for (genvar gi = 0; gi < 2*N-1; gi++) begin : g_pp
            assign pp[gi] = b[gi] ? (PW'(a) << gi) : '0;
        end
    endgenerate

    // Carry-less product, then fold every bit above degree N-1 back in from the top down.
    always_comb begin
        prod = '0;
        for (int i = 0; i < 2*N-1; i++) begin
            prod = prod ^ pp[i];
        end
        for (int i = PW-1; i >= N; i--) begin
            if (prod[i]) begin
                prod = prod ^ (PW'(p) << (i-N));
            end
        end
        y = prod[N-1:0];
    end
endmodule

module gf_pow_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_base,
    input  logic [N-1:0] in_exp,
    input  logic [N:0]   in_poly,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         busy
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   base_q, base_d;
    logic [N-1:0]   exp_q, exp_d;
    logic [N:0]     poly_q, poly_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   sq;
    logic [N-1:0]   prod;
    logic [N-1:0]   nxt;

    galois_multiplication #(.N(N)) u_square (
        .a ({{(N-1){1'b0}}, acc_q}),
        .b ({{(N-1){1'b0}}, acc_q}),
        .p (poly_q),
        .y (sq)
    );

    galois_multiplication #(.N(N)) u_mult (
        .a ({{(N-1){1'b0}}, sq}),
        .b ({{(N-1){1'b0}}, base_q}),
        .p (poly_q),
        .y (prod)
    );

    assign nxt = exp_q[cnt_q] ? prod : sq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            exp_q   <= '0;
            poly_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            poly_q  <= poly_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        exp_d     = exp_q;
        poly_d    = poly_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    base_d  = in_base;
                    exp_d   = in_exp;
                    poly_d  = in_poly;
                    acc_d   = N'(1);
                    cnt_d   = CW'(N-1);
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                acc_d = nxt;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_result = acc_q;
endmodule

// File: tb/tb_gf_pow_seq.sv
// Bench for gf_pow_seq: reference model by repeated field multiplication, per-cycle compare
// of handshake/result against a transaction-level model, plus directed vectors.

module tb_gf_pow_seq;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_base = '0;
    logic [N-1:0] in_exp = '0;
    logic [N:0]   in_poly = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    gf_pow_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_base    (in_base),
        .in_exp     (in_exp),
        .in_poly    (in_poly),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Shift-and-add field multiply, reducing after every doubling.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b, input logic [8:0] p);
        logic [8:0] x;
        logic [7:0] r;
        x = {1'b0, a};
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x[7:0];
            x = x << 1;
            if (x[8]) x = x ^ p;
        end
        return r;
    endfunction

    // base^exp as exp successive multiplications starting from 1.
    function automatic logic [7:0] gpow(input logic [7:0] b, input logic [7:0] e, input logic [8:0] p);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < int'(e); k++) r = gmul(r, b, p);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Transaction-level model: 0 idle, 1 computing, 2 holding result.
    int         m_phase;
    int         m_left;
    logic [7:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_res   <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_left  <= N;
                    m_res   <= gpow(in_base, in_exp, in_poly);
                end
                1: if (m_left == 1) m_phase <= 2; else m_left <= m_left - 1;
                2: if (out_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            if (m_phase == 2) chk("out_result", out_result, m_res);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic request(input logic [7:0] b, input logic [7:0] e, input logic [8:0] p);
        in_base  = b;
        in_exp   = e;
        in_poly  = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 60);
        if (!out_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [7:0] b, input logic [7:0] e,
                          input logic [8:0] p, input logic [7:0] expv);
        int lat;
        request(b, e, p);
        wait_valid(name, lat);
        chk({name, "_lat"}, lat, N);
        chk(name, out_result, expv);
        handshake();
        chk({name, "_rdy"}, in_ready, 1);
        $display("op %s base=%02h exp=%02h poly=%03h result=%02h", name, b, e, p, out_result);
    endtask

    initial begin
        int lat;
        int k;
        logic hs;
        logic [7:0] rb, re;
        logic [8:0] rp;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_result", out_result, 0);
        rst_n = 1'b1;

        chk("model_inv53", gpow(8'h53, 8'hFE, 9'h11B), 8'hCA);
        chk("model_invCA", gpow(8'hCA, 8'hFE, 9'h11B), 8'h53);
        chk("model_2p8", gpow(8'h02, 8'h08, 9'h11B), 8'h1B);
        chk("model_0p0", gpow(8'h00, 8'h00, 9'h11B), 8'h01);

        @(posedge clk); #1;
        run_op("inv53",  8'h53, 8'hFE, 9'h11B, 8'hCA);
        run_op("invCA",  8'hCA, 8'hFE, 9'h11B, 8'h53);
        run_op("pow2_8", 8'h02, 8'h08, 9'h11B, 8'h1B);
        run_op("pow57_1", 8'h57, 8'h01, 9'h11B, 8'h57);
        run_op("pow2_ff", 8'h02, 8'hFF, 9'h11B, 8'h01);
        run_op("pow3_0", 8'h03, 8'h00, 9'h11B, 8'h01);
        run_op("inv0",   8'h00, 8'hFE, 9'h11B, 8'h00);
        run_op("zero0",  8'h00, 8'h00, 9'h11B, 8'h01);

        // Backpressure: result must hold and a second request must be refused.
        request(8'h53, 8'hFE, 9'h11B);
        wait_valid("bp", lat);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_base  = 8'h02;
            in_exp   = 8'h08;
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_result", out_result, 8'hCA);
            chk("bp_hold_rdy", in_ready, 0);
        end
        in_valid = 1'b0;
        handshake();
        chk("bp_rdy_after", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_no_second", busy, 0);
        $display("op backpressure result=CA stalled=20");

        // Inputs wiggle during the computation.
        request(8'h53, 8'hFE, 9'h11B);
        for (int i = 0; i < N - 1; i++) begin
            in_base = 8'($urandom);
            in_exp  = 8'($urandom);
            in_poly = 9'($urandom);
            @(posedge clk); #1;
        end
        wait_valid("iso", lat);
        chk("iso_result", out_result, 8'hCA);
        handshake();
        $display("op isolation result=%02h", out_result);

        // Asynchronous abort partway through.
        request(8'h53, 8'hFE, 9'h11B);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_result", out_result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("op abort");
        run_op("post_abort", 8'h02, 8'h08, 9'h11B, 8'h1B);

        // Random powers, random polynomials, random out_ready stalls.
        for (int t = 0; t < 1500; t++) begin
            rb = 8'($urandom);
            re = 8'($urandom);
            rp = (t % 2 == 0) ? 9'h11B : {1'b1, 8'($urandom)};
            request(rb, re, rp);
            k  = 0;
            hs = 1'b0;
            while (!hs && k < 300) begin
                out_ready = ($urandom_range(0, 3) != 0);
                hs = out_valid && out_ready;
                @(posedge clk); #1;
                k++;
            end
            out_ready = 1'b0;
            if (!hs) chk("rand_timeout", 0, 1);
            $display("rand %0d base=%02h exp=%02h poly=%03h result=%02h", t, rb, re, rp, out_result);
        end

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
